// File: rtl/dmem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_access_ctrl_pkg
//  Purpose  : Shared widths, latency default and FSM state encoding for the
//             data-memory access controller.
//  Revision : 1.0  initial release
// ============================================================================
package dmem_access_ctrl_pkg;

    localparam int LEN_ADR_MEM = 8;                 // word-address width to memory
    localparam int LEN_DATA    = 32;                // data word width
    localparam int SIZE_MEM    = 1 << LEN_ADR_MEM;  // words in data memory
    localparam int DMEM_LAT    = 2;                 // cycles each strobe is held

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // Word accesses only: any nonzero byte offset is an alignment error.
    function automatic logic is_misaligned(input logic [1:0] i_lsb);
        return (i_lsb != 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_access_ctrl_if
//  Purpose  : Request/response channel between the pipeline MEM stage
//             (master) and the data-memory access controller (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W+1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_access_ctrl
//  Purpose  : Bus master for the data memory. Accepts one word load/store per
//             handshake, holds the strobe for MEM_LAT cycles, then returns
//             load data or an alignment error on the response channel.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W  = LEN_ADR_MEM,
    parameter int DATA_W  = LEN_DATA,
    parameter int MEM_LAT = DMEM_LAT
) (
    input  wire logic              clk,
    input  wire logic              rst,
    dmem_access_ctrl_if.slave      bus,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [ADDR_W-1:0]      mem_adr,
    output logic [DATA_W-1:0]      mem_data,
    input  wire logic [DATA_W-1:0] mem_out
);

    localparam int                 c_CNT_W    = $clog2(MEM_LAT) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(MEM_LAT - 1);

    state_t              r_state,      w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt,        w_cnt_nxt;
    logic                r_mem_read,   w_mem_read_nxt;
    logic                r_mem_write,  w_mem_write_nxt;
    logic [ADDR_W-1:0]   r_mem_adr,    w_mem_adr_nxt;
    logic [DATA_W-1:0]   r_mem_data,   w_mem_data_nxt;
    logic                r_resp_valid, w_resp_valid_nxt;
    logic [DATA_W-1:0]   r_resp_rdata, w_resp_rdata_nxt;
    logic                r_resp_err,   w_resp_err_nxt;

    // State, access counter and every registered output; reset discards any in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_adr    <= '0;
            r_mem_data   <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_mem_read   <= w_mem_read_nxt;
            r_mem_write  <= w_mem_write_nxt;
            r_mem_adr    <= w_mem_adr_nxt;
            r_mem_data   <= w_mem_data_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_resp_err   <= w_resp_err_nxt;
        end
    end

    // Next-state and next-output logic; everything holds unless a transition changes it.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_mem_read_nxt   = r_mem_read;
        w_mem_write_nxt  = r_mem_write;
        w_mem_adr_nxt    = r_mem_adr;
        w_mem_data_nxt   = r_mem_data;
        w_resp_valid_nxt = r_resp_valid;
        w_resp_rdata_nxt = r_resp_rdata;
        w_resp_err_nxt   = r_resp_err;

        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (is_misaligned(bus.req_addr[1:0])) begin
                        // Error responses skip the memory entirely.
                        w_resp_valid_nxt = 1'b1;
                        w_resp_err_nxt   = 1'b1;
                        w_resp_rdata_nxt = '0;
                        w_state_nxt      = S_RESP;
                    end else begin
                        w_mem_adr_nxt   = bus.req_addr[ADDR_W+1:2];
                        if (bus.req_we) begin
                            w_mem_data_nxt = bus.req_wdata;
                        end
                        w_mem_read_nxt  = ~bus.req_we;
                        w_mem_write_nxt = bus.req_we;
                        w_cnt_nxt       = c_CNT_INIT;
                        w_state_nxt     = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    // Last strobe cycle: memory output is valid for the held address.
                    w_resp_rdata_nxt = r_mem_read ? mem_out : '0;
                    w_resp_err_nxt   = 1'b0;
                    w_resp_valid_nxt = 1'b1;
                    w_mem_read_nxt   = 1'b0;
                    w_mem_write_nxt  = 1'b0;
                    w_state_nxt      = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    w_resp_valid_nxt = 1'b0;
                    w_state_nxt      = S_IDLE;
                end
            end
            default: begin
                w_mem_read_nxt   = 1'b0;
                w_mem_write_nxt  = 1'b0;
                w_resp_valid_nxt = 1'b0;
                w_state_nxt      = S_IDLE;
            end
        endcase
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_adr        = r_mem_adr;
    assign mem_data       = r_mem_data;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_access_ctrl
//  Purpose  : Self-checking bench for dmem_access_ctrl with a behavioural
//             data memory, directed scenarios and randomized traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_access_ctrl;
    import dmem_access_ctrl_pkg::*;

    localparam int AW  = LEN_ADR_MEM;
    localparam int DW  = LEN_DATA;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mem_out;

    dmem_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_adr   (mem_adr),
        .mem_data  (mem_data),
        .mem_out   (mem_out)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: asynchronous read, write on the clock edge.
    logic [DW-1:0] mem [SIZE_MEM];
    assign mem_out = mem[mem_adr];
    always @(posedge clk) if (mem_write) mem[mem_adr] <= mem_data;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: word-addressed store of everything committed so far.
    typedef struct {
        logic          we;
        logic          err;
        logic [AW-1:0] word;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            acc;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] ref_mem [int];
    int            ncyc = 0;
    int            strb_w = 0;
    bit            prev_v = 0;
    logic [DW-1:0] held_r;
    logic          held_e;

    // Scoreboard monitor: records accepted requests, checks strobes and responses.
    always @(negedge clk) begin
        exp_t e;
        int   k;
        ncyc++;
        if (rst) begin
            q.delete();
            strb_w = 0;
            prev_v = 0;
        end else begin
            if (mem_read || mem_write) begin
                strb_w++;
                if (q.size() == 0) begin
                    chk(0, "strobe_without_request", {mem_read, mem_write}, 0);
                end else begin
                    chk(!(mem_read && mem_write) && !q[0].err && (mem_write == q[0].we)
                        && (mem_adr == q[0].word) && (!q[0].we || mem_data == q[0].wdata),
                        "strobe_ctl", {mem_read, mem_write, mem_adr, mem_data},
                        {~q[0].we, q[0].we, q[0].word, q[0].wdata});
                end
            end else if (strb_w != 0) begin
                chk(strb_w == LAT, "strobe_width", strb_w, LAT);
                strb_w = 0;
            end

            if (bus.resp_valid && !prev_v) begin
                if (q.size() == 0) begin
                    chk(0, "resp_without_request", bus.resp_rdata, 0);
                end else begin
                    e = q.pop_front();
                    chk(bus.resp_rdata == e.rdata, "resp_rdata", bus.resp_rdata, e.rdata);
                    chk(bus.resp_err == e.err, "resp_err", bus.resp_err, e.err);
                    chk(ncyc - e.acc == (e.err ? 1 : LAT + 1), "resp_latency",
                        ncyc - e.acc, e.err ? 1 : LAT + 1);
                end
                held_r = bus.resp_rdata;
                held_e = bus.resp_err;
            end else if (bus.resp_valid) begin
                chk(bus.resp_rdata == held_r && bus.resp_err == held_e, "resp_stable",
                    {bus.resp_err, bus.resp_rdata}, {held_e, held_r});
            end
            prev_v = bus.resp_valid;

            if (bus.req_valid && bus.req_ready) begin
                k       = int'(bus.req_addr >> 2);
                e.we    = bus.req_we;
                e.err   = (bus.req_addr % 4) != 0;
                e.word  = AW'(k);
                e.wdata = bus.req_wdata;
                e.acc   = ncyc;
                if (e.err)           e.rdata = '0;
                else if (e.we) begin ref_mem[k] = bus.req_wdata; e.rdata = '0; end
                else                 e.rdata = ref_mem.exists(k) ? ref_mem[k] : '0;
                q.push_back(e);
            end
        end
    end

    // Drive one request and hold it until the controller takes it.
    task automatic issue(input logic we, input logic [AW+1:0] addr, input logic [DW-1:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        wait_accept();
    endtask

    task automatic wait_accept();
        int n = 0;
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            if (++n > 200) begin
                chk(0, "accept_timeout", n, 200);
                break;
            end
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || bus.resp_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(q.size() == 0 && !bus.resp_valid, "drain", q.size(), 0);
        @(posedge clk); #1;
    endtask

    bit rand_done;

    initial begin
        for (int i = 0; i < SIZE_MEM; i++) mem[i] = '0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk(!mem_read && !mem_write && mem_adr == 0 && mem_data == 0, "reset_mem_side",
            {mem_read, mem_write, mem_adr, mem_data}, 0);
        chk(!bus.resp_valid && bus.resp_rdata == 0 && !bus.resp_err, "reset_resp",
            {bus.resp_valid, bus.resp_err, bus.resp_rdata}, 0);
        chk(bus.req_ready && !bus.busy, "reset_ready_busy", {bus.req_ready, bus.busy}, 2'b10);
        @(posedge clk); #1 rst = 1'b0;

        // Aligned store, then load back, then a misaligned load.
        issue(1'b1, 10'h010, 32'hDEADBEEF);
        drain();
        issue(1'b0, 10'h010, '0);
        drain();
        issue(1'b0, 10'h013, '0);
        drain();

        // Response back-pressure: a second request must wait for the handshake.
        bus.resp_ready = 1'b0;
        issue(1'b1, 10'h040, 32'h12345678);
        for (int n = 0; n < 20 && !bus.resp_valid; n++) @(negedge clk);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 10'h040;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk(bus.resp_valid && !bus.req_ready && bus.busy && !mem_read, "backpressure_hold",
                {bus.resp_valid, bus.req_ready, bus.busy, mem_read}, 4'b1010);
        end
        @(posedge clk); #1 bus.resp_ready = 1'b1;
        wait_accept();
        drain();

        // Asynchronous reset in the second strobe cycle of a store.
        issue(1'b1, 10'h020, 32'hCAFEF00D);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk(!mem_read && !mem_write && !bus.resp_valid && bus.req_ready && !bus.busy,
            "async_reset_abort", {mem_read, mem_write, bus.resp_valid, bus.req_ready, bus.busy},
            5'b00010);
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        issue(1'b0, 10'h020, '0);
        drain();

        // Randomized back-to-back traffic with random response back-pressure.
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    logic [AW+1:0] a;
                    a = {AW'($urandom_range(0, 15)),
                         2'(($urandom % 4 == 0) ? $urandom_range(1, 3) : 0)};
                    issue(1'($urandom % 2), a, $urandom);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 bus.resp_ready = ($urandom % 4) != 0;
                end
                bus.resp_ready = 1'b1;
            end
        join
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
